// File: rtl/cdb_issue_scheduler.sv
// Per-cycle issue arbiter for Int/Lsb/Mul/Div queues with CDB slot reservation and divider tracking.
// Optional issue statistics counters are built when ISSUE_STATS_EN is defined.
module cdb_issue_scheduler #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IntQ_Ready,
  input  logic        Lsbuf_Ready,
  input  logic        MulQ_Ready,
  input  logic        DivQ_Ready,
  input  logic        Cdb_Flush,
  output logic        Iss_Int,
  output logic        Iss_Lsb,
  output logic        Iss_Mul,
  output logic        Iss_Div,
  output logic        Iss_DivBusy
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0] Iss_StallCnt,
  output logic [15:0] Iss_GrantCnt
`endif
);

  localparam int unsigned DCNT_W = 5;

  logic [DIV_LAT-1:0] slotRes, slotResNxt;
  logic [DCNT_W-1:0]  divCnt, divCntNxt;
  logic               lastLsb, lastLsbNxt;
  logic               issOk, slotFree;

  // Grants: flush and reset suppress everything; slot 0 reservation blocks Int/Lsb.
  always_comb begin
    issOk       = ~Reset & ~Cdb_Flush;
    slotFree    = issOk & ~slotRes[0];
    Iss_Int     = slotFree & IntQ_Ready & (~Lsbuf_Ready | lastLsb);
    Iss_Lsb     = slotFree & Lsbuf_Ready & (~IntQ_Ready | ~lastLsb);
    Iss_Mul     = issOk & MulQ_Ready & ~slotRes[MUL_LAT];
    // The divider frees up on the cycle its result reaches the CDB input.
    Iss_Div     = issOk & DivQ_Ready & (divCnt <= DCNT_W'(1));
    Iss_DivBusy = ~Reset & (divCnt != '0);
  end

  // Next-state: shift reservations, count down divider, remember round-robin winner.
  always_comb begin
    slotResNxt = slotRes >> 1;
    divCntNxt  = divCnt;
    lastLsbNxt = lastLsb;
    if (Iss_Mul) slotResNxt[MUL_LAT-1] = 1'b1;
    if (Iss_Div) slotResNxt[DIV_LAT-1] = 1'b1;
    if (Iss_Div)
      divCntNxt = DCNT_W'(DIV_LAT);
    else if (divCnt != '0)
      divCntNxt = divCnt - DCNT_W'(1);
    if (Iss_Int | Iss_Lsb) lastLsbNxt = Iss_Lsb;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      slotRes <= '0;
      divCnt  <= '0;
      lastLsb <= 1'b1;
    end else begin
      slotRes <= slotResNxt;
      divCnt  <= divCntNxt;
      lastLsb <= lastLsbNxt;
    end
  end

`ifdef ISSUE_STATS_EN
  logic        stallHit;
  logic [1:0]  grantNum;
  logic [16:0] stallSum, grantSum;

  // Saturating statistics counters.
  always_comb begin
    stallHit = (IntQ_Ready | Lsbuf_Ready) & slotRes[0] & ~Cdb_Flush;
    grantNum = 2'(Iss_Int | Iss_Lsb) + 2'(Iss_Mul) + 2'(Iss_Div);
    stallSum = {1'b0, Iss_StallCnt} + 17'(stallHit);
    grantSum = {1'b0, Iss_GrantCnt} + 17'(grantNum);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Iss_StallCnt <= '0;
      Iss_GrantCnt <= '0;
    end else begin
      Iss_StallCnt <= stallSum[16] ? 16'hFFFF : stallSum[15:0];
      Iss_GrantCnt <= grantSum[16] ? 16'hFFFF : grantSum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Self-checking bench for cdb_issue_scheduler: absolute-time CDB calendar model plus directed literal checks.
module tb_cdb_issue_scheduler;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 7;
  localparam int NRAND   = 10000;
  localparam int NMAX    = NRAND + 400;

  logic Clk;
  logic Reset, IntQ_Ready, Lsbuf_Ready, MulQ_Ready, DivQ_Ready, Cdb_Flush;
  logic Iss_Int, Iss_Lsb, Iss_Mul, Iss_Div, Iss_DivBusy;
`ifdef ISSUE_STATS_EN
  logic [15:0] Iss_StallCnt, Iss_GrantCnt;
`endif

  cdb_issue_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .Clk(Clk), .Reset(Reset),
    .IntQ_Ready(IntQ_Ready), .Lsbuf_Ready(Lsbuf_Ready),
    .MulQ_Ready(MulQ_Ready), .DivQ_Ready(DivQ_Ready), .Cdb_Flush(Cdb_Flush),
    .Iss_Int(Iss_Int), .Iss_Lsb(Iss_Lsb), .Iss_Mul(Iss_Mul), .Iss_Div(Iss_Div),
    .Iss_DivBusy(Iss_DivBusy)
`ifdef ISSUE_STATS_EN
    , .Iss_StallCnt(Iss_StallCnt), .Iss_GrantCnt(Iss_GrantCnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors, checks, n;
  // Calendar indexed by absolute cycle: is the CDB input claimed by a Mul/Div Done then?
  bit mBusy [0:NMAX+32];
  bit dMul  [0:NMAX+32];
  bit dDiv  [0:NMAX+32];
  int mLastDiv, mStall, mGrant;
  bit mLastLsb;
  logic sInt, sLsb, sMul, sDiv, sBusy;
  logic [15:0] sStall, sGrant;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, n, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, n, act, exp);
    end
  endtask

  // One clock: drive inputs, sample at negedge, compare with model, advance model.
  task automatic cyc(input bit r, input bit i, input bit l, input bit m, input bit d, input bit f);
    bit eInt, eLsb, eMul, eDiv, eBusy, free;
    int dones;
    Reset = r; IntQ_Ready = i; Lsbuf_Ready = l; MulQ_Ready = m; DivQ_Ready = d; Cdb_Flush = f;
    @(negedge Clk);
    sInt = Iss_Int; sLsb = Iss_Lsb; sMul = Iss_Mul; sDiv = Iss_Div; sBusy = Iss_DivBusy;
`ifdef ISSUE_STATS_EN
    sStall = Iss_StallCnt; sGrant = Iss_GrantCnt;
`else
    sStall = '0; sGrant = '0;
`endif
    free  = !r && !f && !mBusy[n];
    eInt  = free && i && (!l || mLastLsb);
    eLsb  = free && l && (!i || !mLastLsb);
    eMul  = !r && !f && m && !mBusy[n+MUL_LAT];
    eDiv  = !r && !f && d && (n >= mLastDiv + DIV_LAT);
    eBusy = !r && (n > mLastDiv) && (n <= mLastDiv + DIV_LAT);
    chk1("iss_int", sInt, eInt);
    chk1("iss_lsb", sLsb, eLsb);
    chk1("iss_mul", sMul, eMul);
    chk1("iss_div", sDiv, eDiv);
    chk1("iss_divbusy", sBusy, eBusy);
`ifdef ISSUE_STATS_EN
    chk16("stall_cnt", sStall, 16'(mStall));
    chk16("grant_cnt", sGrant, 16'(mGrant));
`endif
    if (!r) begin
      dones = int'(sInt | sLsb) + int'(dMul[n]) + int'(dDiv[n]);
      chk16("cdb_onehot", 16'(dones), (dones <= 1) ? 16'(dones) : 16'd1);
    end
    if (r) begin
      for (int k = n + 1; k <= n + DIV_LAT + 1; k++) begin
        mBusy[k] = 0; dMul[k] = 0; dDiv[k] = 0;
      end
      mLastDiv = -1000; mLastLsb = 1; mStall = 0; mGrant = 0;
    end else begin
      if (eMul) mBusy[n+MUL_LAT] = 1;
      if (eDiv) begin mBusy[n+DIV_LAT] = 1; mLastDiv = n; end
      if (sMul === 1'b1) dMul[n+MUL_LAT] = 1;
      if (sDiv === 1'b1) dDiv[n+DIV_LAT] = 1;
      if (eInt || eLsb) mLastLsb = eLsb;
      if ((i || l) && mBusy[n] && !f && mStall < 65535) mStall++;
      mGrant = mGrant + int'(eInt) + int'(eLsb) + int'(eMul) + int'(eDiv);
      if (mGrant > 65535) mGrant = 65535;
    end
    n++;
    @(posedge Clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", n);
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0; checks = 0; n = 0;
    mLastDiv = -1000; mLastLsb = 1; mStall = 0; mGrant = 0;
    Reset = 1; IntQ_Ready = 0; Lsbuf_Ready = 0; MulQ_Ready = 0; DivQ_Ready = 0; Cdb_Flush = 0;
    @(posedge Clk); #1;

    // Reset held with everything ready, then first cycle grants Int+Mul+Div.
    repeat (3) begin
      cyc(1, 1, 1, 1, 1, 0);
      chk1("rst_int", sInt, 1'b0); chk1("rst_lsb", sLsb, 1'b0);
      chk1("rst_mul", sMul, 1'b0); chk1("rst_div", sDiv, 1'b0);
      chk1("rst_busy", sBusy, 1'b0);
    end
    cyc(0, 1, 1, 1, 1, 0);
    chk1("first_int", sInt, 1'b1); chk1("first_lsb", sLsb, 1'b0);
    chk1("first_mul", sMul, 1'b1); chk1("first_div", sDiv, 1'b1);

    // Round-robin Int/Lsb.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 1, 0, 0, 0);
      chk1("rr_int", sInt, 1'((k % 2) == 0));
      chk1("rr_lsb", sLsb, 1'((k % 2) == 1));
    end

    // Mul at cycle 10 blocks Int at cycle 14 only.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k <= 20; k++) begin
      cyc(0, 1, 0, k == 10, 0, 0);
      chk1("mulblk_int", sInt, 1'(k != 14));
`ifdef ISSUE_STATS_EN
      if (k == 20) chk16("mulblk_stall", sStall, 16'd1);
`endif
    end

    // Div at 0: Mul suppressed at 3, next Div at 7, busy 1..7.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k <= 7; k++) begin
      cyc(0, 0, 0, k == 3, 1, 0);
      chk1("div_grant", sDiv, 1'(k == 0 || k == 7));
      chk1("div_busy", sBusy, 1'(k >= 1));
      if (k == 3) chk1("div_mulsup", sMul, 1'b0);
    end

    // Flush at cycle 5; Mul from cycle 2 still blocks Int/Lsb at 6.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k <= 6; k++) begin
      cyc(0, 1, 1, 1, 1, k == 5);
      if (k == 2) chk1("fl_mul2", sMul, 1'b1);
      if (k == 5) begin
        chk1("fl_int", sInt, 1'b0); chk1("fl_lsb", sLsb, 1'b0);
        chk1("fl_mul", sMul, 1'b0); chk1("fl_div", sDiv, 1'b0);
      end
      if (k == 6) begin
        chk1("fl_blk_int", sInt, 1'b0); chk1("fl_blk_lsb", sLsb, 1'b0);
      end
    end

    // Back-to-back multiplies never self-collide.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 1, 0, 0);
      chk1("mul_stream", sMul, 1'b1);
    end

    // Randomized traffic with occasional flush and mid-operation reset.
    for (int k = 0; k < NRAND; k++) begin
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
